// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 9;
    localparam int WAIT_W      = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational winner select for the data-memory port.
// DMEM_ARB_RR_EN selects round-robin contention resolution instead of fixed core priority.
module dmem_arb_grant
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              enable,
    input  logic              core_valid,
    input  logic              ext_valid,
    input  logic [WAIT_W-1:0] wait_cnt,
`ifdef DMEM_ARB_RR_EN
    input  owner_e            last_grant,
`endif
    output owner_e            winner
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    always_comb begin
        winner = OWN_NONE;
        if (enable) begin
            if (core_valid && ext_valid) begin
                // Starvation escape overrides the normal tie-break
                if (wait_cnt == WAIT_MAX) begin
                    winner = OWN_EXT;
                end else begin
`ifdef DMEM_ARB_RR_EN
                    winner = (last_grant == OWN_CORE) ? OWN_EXT : OWN_CORE;
`else
                    winner = OWN_CORE;
`endif
                end
            end else if (core_valid) begin
                winner = OWN_CORE;
            end else if (ext_valid) begin
                winner = OWN_EXT;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage and an external requester.
// Define DMEM_ARB_RR_EN for round-robin contention; default is core priority with ext starvation escape.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req_valid,
    input  logic              core_req_we,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_wdata,
    output logic              core_req_ready,
    output logic              core_stall,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rsp_rdata,
    input  logic              ext_req_valid,
    input  logic              ext_req_we,
    input  logic [ADDR_W-1:0] ext_req_addr,
    input  logic [DATA_W-1:0] ext_req_wdata,
    output logic              ext_req_ready,
    output logic              ext_rsp_valid,
    output logic [DATA_W-1:0] ext_rsp_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    owner_e            winner;
    owner_e            rsp_owner_p1;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;
    dmem_req_t         core_req;
    dmem_req_t         ext_req;
    dmem_req_t         win_req;

`ifdef DMEM_ARB_RR_EN
    owner_e last_grant;
`endif

    // Grants are suppressed while reset is asserted so every output reads 0
    dmem_arb_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
        .enable     (reset),
        .core_valid (core_req_valid),
        .ext_valid  (ext_req_valid),
        .wait_cnt   (wait_cnt),
`ifdef DMEM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .winner     (winner)
    );

    assign core_req = '{we: core_req_we, addr: core_req_addr, wdata: core_req_wdata};
    assign ext_req  = '{we: ext_req_we,  addr: ext_req_addr,  wdata: ext_req_wdata};
    assign win_req  = (winner == OWN_EXT) ? ext_req : core_req;

    assign core_req_ready = (winner == OWN_CORE);
    assign ext_req_ready  = (winner == OWN_EXT);
    assign core_stall     = reset & core_req_valid & ~core_req_ready;
    assign accept         = (winner != OWN_NONE);

    assign mem_wr    = accept &  win_req.we;
    assign mem_rd    = accept & ~win_req.we;
    assign mem_addr  = accept ? win_req.addr  : '0;
    assign mem_wdata = accept ? win_req.wdata : '0;

    assign core_rsp_valid = (rsp_owner_p1 == OWN_CORE);
    assign ext_rsp_valid  = (rsp_owner_p1 == OWN_EXT);
    assign core_rsp_rdata = core_rsp_valid ? mem_rdata : '0;
    assign ext_rsp_rdata  = ext_rsp_valid  ? mem_rdata : '0;

    // Stage p1: read owner for the data returning next cycle; ext starvation count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_owner_p1 <= OWN_NONE;
            wait_cnt     <= '0;
        end else begin
            rsp_owner_p1 <= mem_rd ? winner : OWN_NONE;
            if (ext_req_valid && !ext_req_ready) begin
                wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= OWN_EXT;
        end else if (core_req_valid && ext_req_valid) begin
            last_grant <= winner;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios then constrained-random traffic.
// Follows DMEM_ARB_RR_EN the same way the design does.
module tb_dmem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cv, cwe, ev, ewe;
    logic [8:0]  caddr, eaddr;
    logic [31:0] cwdata, ewdata;
    logic        core_req_ready, core_stall, core_rsp_valid;
    logic [31:0] core_rsp_rdata;
    logic        ext_req_ready, ext_rsp_valid;
    logic [31:0] ext_rsp_rdata;
    logic        mem_wr, mem_rd;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(cv), .core_req_we(cwe), .core_req_addr(caddr), .core_req_wdata(cwdata),
        .core_req_ready(core_req_ready), .core_stall(core_stall),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
        .ext_req_valid(ev), .ext_req_we(ewe), .ext_req_addr(eaddr), .ext_req_wdata(ewdata),
        .ext_req_ready(ext_req_ready), .ext_rsp_valid(ext_rsp_valid), .ext_rsp_rdata(ext_rsp_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Simple synchronous RAM; unread cycles return garbage so rdata gating is exercised
    logic [31:0] mem [512];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem_rd ? mem[mem_addr] : $urandom();
        end
    end

    // Reference model state
    logic [31:0] ref_mem [512];
    int          ext_lost, last_c, win, last_win;
    logic        pend_v;
    int          pend_o;
    logic [31:0] pend_d;
    logic        w_we;
    logic [8:0]  w_addr;
    logic [31:0] w_wd;
    logic        got_crdy, got_erdy, got_mrd, got_crv, got_erv;
    logic [31:0] got_crd;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task tick();
        #1;
        if (!reset) pend_v = 1'b0;
        win = 0;
        if (reset) begin
            if (cv && ev) begin
                if (ext_lost == MAX_WAIT) win = 2;
`ifdef DMEM_ARB_RR_EN
                else win = (last_c == 1) ? 2 : 1;
`else
                else win = 1;
`endif
            end else if (cv) win = 1;
            else if (ev) win = 2;
        end
        w_we   = (win == 2) ? ewe    : cwe;
        w_addr = (win == 2) ? eaddr  : caddr;
        w_wd   = (win == 2) ? ewdata : cwdata;
        chk("core_ready", core_req_ready, win == 1);
        chk("ext_ready",  ext_req_ready,  win == 2);
        chk("core_stall", core_stall, reset && cv && win != 1);
        chk("mem_wr",     mem_wr, win != 0 && w_we);
        chk("mem_rd",     mem_rd, win != 0 && !w_we);
        chk("mem_addr",   mem_addr,  (win != 0) ? w_addr : 9'h0);
        chk("mem_wdata",  mem_wdata, (win != 0) ? w_wd : 32'h0);
        chk("core_rsp_valid", core_rsp_valid, pend_v && pend_o == 1);
        chk("core_rsp_rdata", core_rsp_rdata, (pend_v && pend_o == 1) ? pend_d : 32'h0);
        chk("ext_rsp_valid",  ext_rsp_valid,  pend_v && pend_o == 2);
        chk("ext_rsp_rdata",  ext_rsp_rdata,  (pend_v && pend_o == 2) ? pend_d : 32'h0);
        got_crdy = core_req_ready; got_erdy = ext_req_ready; got_mrd = mem_rd;
        got_crv  = core_rsp_valid; got_crd  = core_rsp_rdata; got_erv = ext_rsp_valid;
        last_win = win;
        @(posedge clk);
        if (reset) begin
            pend_v = (win != 0 && !w_we);
            pend_o = win;
            pend_d = ref_mem[w_addr];
            if (win != 0 && w_we) ref_mem[w_addr] = w_wd;
            if (ev && win != 2) ext_lost = (ext_lost < MAX_WAIT) ? ext_lost + 1 : MAX_WAIT;
            else ext_lost = 0;
            if (cv && ev) last_c = win;
        end else begin
            pend_v = 1'b0; ext_lost = 0; last_c = 2;
        end
        @(negedge clk);
    endtask

    task idle();
        cv = 1'b0; ev = 1'b0; cwe = 1'b0; ewe = 1'b0;
        caddr = '0; eaddr = '0; cwdata = '0; ewdata = '0;
    endtask

    function automatic logic [8:0] pick_addr();
        return ($urandom_range(0, 4) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        ext_lost = 0; last_c = 2; pend_v = 1'b0; pend_o = 0; pend_d = '0;
        mem_clr = 1'b1;
        reset = 1'b0;
        idle();
        // Reset with both requesters active: everything quiet
        cv = 1'b1; ev = 1'b1; caddr = 9'h003; eaddr = 9'h004;
        @(negedge clk);
        tick();
        tick();
        mem_clr = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_release_core_first", got_crdy, 1'b1);
        idle();
        tick();

        // Ext preloads 0x010, then core reads it back
        ev = 1'b1; ewe = 1'b1; eaddr = 9'h010; ewdata = 32'hDEADBEEF;
        tick();
        idle();
        tick();
        cv = 1'b1; cwe = 1'b0; caddr = 9'h010;
        tick();
        chk("core_rd_strobe", got_mrd, 1'b1);
        idle();
        tick();
        chk("core_rsp_valid_n1", got_crv, 1'b1);
        chk("core_rsp_data_n1",  got_crd, 32'hDEADBEEF);
        chk("ext_rsp_quiet",     got_erv, 1'b0);

        // Ext write followed immediately by core read of the same word
        ev = 1'b1; ewe = 1'b1; eaddr = 9'h1FF; ewdata = 32'h12345678;
        tick();
        idle();
        cv = 1'b1; caddr = 9'h1FF;
        tick();
        idle();
        tick();
        chk("wr_then_rd_data", got_crd, 32'h12345678);

        // Continuous contention from a clean reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cv = 1'b1; ev = 1'b1; caddr = 9'h010; eaddr = 9'h1FF;
        for (int i = 0; i < 10; i++) begin
            tick();
`ifdef DMEM_ARB_RR_EN
            chk("contend_pattern", {got_crdy, got_erdy}, (i % 2 == 1) ? 2'b01 : 2'b10);
`else
            chk("contend_pattern", {got_crdy, got_erdy}, (i % 5 == 4) ? 2'b01 : 2'b10);
`endif
        end
        idle();
        tick();

        // Reset pulsed while a read response is pending
        cv = 1'b1; caddr = 9'h010;
        tick();
        idle();
        reset = 1'b0;
        tick();
        chk("rst_kills_rsp", got_crv, 1'b0);
        reset = 1'b1;
        tick();
        chk("no_rsp_after_release", got_crv, 1'b0);

        // Random traffic with requests held until accepted
        for (int n = 0; n < 300; n++) begin
            if (!cv || last_win == 1) begin
                cv = ($urandom_range(0, 3) != 0); cwe = 1'($urandom_range(0, 1));
                caddr = pick_addr(); cwdata = $urandom();
            end
            if (!ev || last_win == 2) begin
                ev = ($urandom_range(0, 1) != 0); ewe = 1'($urandom_range(0, 1));
                eaddr = pick_addr(); ewdata = $urandom();
            end
            tick();
        end
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
